// File: rtl/bch_encoder.sv
// bch_encoder: combinational systematic BCH(15,7) double-error-correcting encoder.
// Generator polynomial g(x) = x^8 + x^7 + x^6 + x^4 + 1 (0x1D1).
// Ports:
//   msg      - 7-bit message
//   codeword - {msg, parity}; message in [14:8], parity in [7:0]
module bch_encoder (
  input  logic [6:0]  msg,
  output logic [14:0] codeword
);

  logic [7:0] parity;

  // Bit-serial LFSR division of msg(x) * x^8 by g(x), fully unrolled.
  always_comb begin
    logic fb;
    parity = 8'h00;
    for (int i = 6; i >= 0; i--) begin
      fb     = msg[i] ^ parity[7];
      parity = {parity[6:0], 1'b0};
      if (fb) begin
        parity = parity ^ 8'hD1;
      end
    end
  end

  assign codeword = {msg, parity};

endmodule

// File: rtl/bch15_enc_arbiter.sv
// bch15_enc_arbiter: round-robin arbiter sharing one BCH(15,7) encoder among NUM_REQ
// requesters. The granted message is encoded, tagged with the requester index and
// pushed into a 2-entry output FIFO with valid/ready backpressure.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_valid   - per-requester message valid
//   req_msg     - requester i message at [7i+6:7i]
//   req_ready   - one-hot grant (combinational from req_valid, rr pointer, fifo count)
//   cw_valid    - FIFO head valid
//   cw_ready    - sink accepts head
//   cw_data     - head codeword (registered)
//   cw_id       - head requester index (registered)
//   enc_count   - accepted-message counter, wraps at 16 bits
module bch15_enc_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [7*NUM_REQ-1:0] req_msg,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 cw_valid,
  input  logic                 cw_ready,
  output logic [14:0]          cw_data,
  output logic [IDW-1:0]       cw_id,
  output logic [15:0]          enc_count
);

  logic [1:0]     count_q, count_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [14:0]    head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [IDW-1:0] head_id_q, head_id_d, tail_id_q, tail_id_d;
  logic [15:0]    enc_count_q;

  logic           space;
  logic           grant_any;
  logic [IDW-1:0] gnt_idx;
  logic [6:0]     sel_msg;
  logic [14:0]    enc_cw;
  logic           push, pop;

  // Only the registered count decides space, keeping cw_ready off the ready path.
  assign space = (count_q < 2'd2);

  // Two-pass search: first valid at or above rr_ptr, else lowest valid below it.
  always_comb begin
    logic           hi_found, lo_found;
    logic [IDW-1:0] hi_idx, lo_idx;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hi_found && req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = IDW'(i);
      end
      if (!lo_found && req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
      end
    end
    grant_any = space & (hi_found | lo_found);
    gnt_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Ready is forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n & grant_any & (gnt_idx == IDW'(i));
    end
  end

  always_comb begin
    sel_msg = 7'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_msg = req_msg[7*i +: 7];
      end
    end
  end

  bch_encoder u_enc (
    .msg      (sel_msg),
    .codeword (enc_cw)
  );

  assign push = grant_any;
  assign pop  = cw_valid & cw_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_id_d   = head_id_q;
    tail_data_d = tail_data_q;
    tail_id_d   = tail_id_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_data_d = enc_cw;
          head_id_d   = gnt_idx;
          count_d     = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d = enc_cw;
          head_id_d   = gnt_idx;
        end else if (push) begin
          tail_data_d = enc_cw;
          tail_id_d   = gnt_idx;
          count_d     = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_id_d   = tail_id_q;
          count_d     = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      rr_ptr_q    <= '0;
      head_data_q <= 15'h0000;
      head_id_q   <= '0;
      tail_data_q <= 15'h0000;
      tail_id_q   <= '0;
      enc_count_q <= 16'h0000;
    end else begin
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      head_data_q <= head_data_d;
      head_id_q   <= head_id_d;
      tail_data_q <= tail_data_d;
      tail_id_q   <= tail_id_d;
      if (push) begin
        enc_count_q <= enc_count_q + 16'd1;
      end
    end
  end

  assign cw_valid  = (count_q != 2'd0);
  assign cw_data   = head_data_q;
  assign cw_id     = head_id_q;
  assign enc_count = enc_count_q;

endmodule

// File: tb/tb_bch15_enc_arbiter.sv
// Self-checking bench for bch15_enc_arbiter (NUM_REQ=4): directed vector table,
// round-robin, backpressure, random scoreboard, mid-operation reset and counter wrap.
module tb_bch15_enc_arbiter;

  localparam int NR  = 4;
  localparam int IDW = 2;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [7*NR-1:0] req_msg;
  logic [NR-1:0]   req_ready;
  logic            cw_valid;
  logic            cw_ready;
  logic [14:0]     cw_data;
  logic [IDW-1:0]  cw_id;
  logic [15:0]     enc_count;

  int checks = 0;
  int errors = 0;

  bch15_enc_arbiter #(
    .NUM_REQ (NR),
    .IDW     (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_msg   (req_msg),
    .req_ready (req_ready),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .cw_data   (cw_data),
    .cw_id     (cw_id),
    .enc_count (enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [6:0]  msg;
    logic [14:0] cw;
  } vec_t;

  typedef struct {
    int          id;
    logic [14:0] cw;
  } entry_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference encoder by polynomial long division.
  function automatic logic [14:0] enc_model(input logic [6:0] m);
    logic [14:0] v;
    v = {m, 8'h00};
    for (int b = 14; b >= 8; b--) begin
      if (v[b]) v = v ^ (15'h01D1 << (b - 8));
    end
    return {m, v[7:0]};
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_msg   = '0;
    cw_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t        vecs[7];
  entry_t      q[$];
  entry_t      e;
  int          ec;
  int          ptr;
  int          g;
  logic [3:0]  exp_rdy;

  initial begin
    vecs[0] = '{id: 0, msg: 7'h01, cw: 15'h01D1};
    vecs[1] = '{id: 2, msg: 7'h7F, cw: 15'h7FFF};
    vecs[2] = '{id: 2, msg: 7'h02, cw: 15'h0273};
    vecs[3] = '{id: 2, msg: 7'h00, cw: 15'h0000};
    vecs[4] = '{id: 1, msg: 7'h04, cw: 15'h04E6};
    vecs[5] = '{id: 3, msg: 7'h08, cw: 15'h081D};
    vecs[6] = '{id: 0, msg: 7'h03, cw: 15'h03A2};

    // Reset: outputs zero, ready gated even with a valid request present.
    rst_n     = 1'b0;
    req_valid = 4'b0001;
    req_msg   = '0;
    cw_ready  = 1'b1;
    #12;
    chk("rst_cw_valid", 32'(cw_valid), 32'd0);
    chk("rst_cw_data", 32'(cw_data), 32'd0);
    chk("rst_cw_id", 32'(cw_id), 32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed encode vectors, one requester at a time, sink always ready.
    ec = 0;
    for (int i = 0; i < 7; i++) begin
      req_valid = '0;
      req_msg   = '0;
      req_valid[vecs[i].id] = 1'b1;
      req_msg[7*vecs[i].id +: 7] = vecs[i].msg;
      cw_ready = 1'b1;
      #1;
      exp_rdy = 4'(1 << vecs[i].id);
      chk("vec_req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      req_valid = '0;
      ec++;
      chk("vec_cw_valid", 32'(cw_valid), 32'd1);
      chk("vec_cw_data", 32'(cw_data), 32'(vecs[i].cw));
      chk("vec_cw_id", 32'(cw_id), 32'(vecs[i].id));
      chk("vec_enc_count", 32'(enc_count), 32'(ec));
    end
    @(posedge clk);
    #1 chk("vec_drain", 32'(cw_valid), 32'd0);

    // Round-robin with all requesters valid, one codeword per cycle.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) req_msg[7*i +: 7] = 7'(i + 1);
    cw_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_rdy = 4'(1 << (k % NR));
      chk("rr_req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      chk("rr_cw_valid", 32'(cw_valid), 32'd1);
      chk("rr_cw_id", 32'(cw_id), 32'(k % NR));
      chk("rr_cw_data", 32'(cw_data), 32'(enc_model(7'((k % NR) + 1))));
    end

    // Backpressure: two grants then stall; a single pop lets requester 2 in.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) req_msg[7*i +: 7] = 7'(i + 1);
    cw_ready = 1'b0;
    #1 chk("bp_grant0", 32'(req_ready), 32'h1);
    @(posedge clk);
    #2 chk("bp_grant1", 32'(req_ready), 32'h2);
    @(posedge clk);
    #2 chk("bp_full_ready", 32'(req_ready), 32'h0);
    chk("bp_head_id", 32'(cw_id), 32'd0);
    chk("bp_enc_count", 32'(enc_count), 32'd2);
    @(posedge clk);
    #1;
    chk("bp_hold_ready", 32'(req_ready), 32'h0);
    chk("bp_hold_id", 32'(cw_id), 32'd0);
    chk("bp_hold_data", 32'(cw_data), 32'(enc_model(7'h01)));
    cw_ready = 1'b1;
    #1 chk("bp_pop_no_space", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    cw_ready = 1'b0;
    #1;
    chk("bp_after_pop_id", 32'(cw_id), 32'd1);
    chk("bp_grant2", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1 chk("bp_full_again", 32'(req_ready), 32'h0);

    // Asynchronous reset with two entries held.
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cw_valid", 32'(cw_valid), 32'd0);
    chk("ar_req_ready", 32'(req_ready), 32'h0);
    chk("ar_enc_count", 32'(enc_count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("ar_first_grant", 32'(req_ready), 32'h1);

    // Random valid/ready traffic against a scoreboard with an arbiter model.
    do_reset();
    q.delete();
    ptr = 0;
    for (int c = 0; c < 1000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) req_msg[7*i +: 7] = 7'($urandom_range(0, 127));
      cw_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      if (q.size() < 2) begin
        for (int k = 0; k < NR; k++) begin
          if (g < 0 && req_valid[(ptr + k) % NR]) g = (ptr + k) % NR;
        end
      end
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'h0;
      chk("sb_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("sb_cw_valid", 32'(cw_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("sb_cw_data", 32'(cw_data), 32'(q[0].cw));
        chk("sb_cw_id", 32'(cw_id), 32'(q[0].id));
      end
      @(posedge clk);
      if (q.size() != 0 && cw_ready) void'(q.pop_front());
      if (g >= 0) begin
        e.id = g;
        e.cw = enc_model(req_msg[7*g +: 7]);
        q.push_back(e);
        ptr = (g + 1) % NR;
      end
      #1;
    end

    // Counter wrap after 65536 accepted messages.
    do_reset();
    req_valid = 4'b0001;
    req_msg   = '0;
    cw_ready  = 1'b1;
    repeat (65535) @(posedge clk);
    #1 chk("wrap_ffff", 32'(enc_count), 32'hFFFF);
    @(posedge clk);
    #1 chk("wrap_zero", 32'(enc_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
